// File: rtl/bus_resp_mem.sv
// Word-addressed memory responder for the req/ack/resp bus: programmable ack wait states,
// byte-enable writes and a fixed-latency, in-order read pipeline with no backpressure.
module bus_resp_mem #(
    parameter int unsigned mem_size   = 1024,
    parameter string       mem_data   = "none",
    parameter int unsigned ACK_WAIT   = 0,
    parameter int unsigned RESP_DELAY = 1,
    parameter logic [31:0] OOR_RDATA  = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo
);

    localparam int unsigned AW       = (mem_size > 1) ? $clog2(mem_size) : 1;
    localparam logic [3:0]  WAIT_MAX = 4'(ACK_WAIT);
    localparam int unsigned LAST     = RESP_DELAY - 1;

    logic [31:0] r_mem [mem_size];

    logic [3:0]  r_wcnt;
    logic [RESP_DELAY-1:0] r_vld;
    logic [31:0] r_dat [RESP_DELAY];

    logic [29:0]   w_idx;
    logic [1:0]    w_unused_lsb;
    logic [AW-1:0] w_word;
    logic          w_in_range;
    logic          w_accept;
    logic          w_rd_fire;
    logic          w_wr_fire;
    logic [31:0]   w_rd_data;

    assign w_idx        = bus_addr_bi[31:2];
    assign w_unused_lsb = bus_addr_bi[1:0];
    assign w_word       = w_idx[AW-1:0];
    assign w_in_range   = ({2'b00, w_idx} < mem_size);

    // Ack is combinational and suppressed while reset is asserted.
    assign bus_ack_o = arst_n_i & bus_req_i & (r_wcnt == WAIT_MAX);
    assign w_accept  = bus_ack_o;
    assign w_rd_fire = w_accept & ~bus_we_i;
    assign w_wr_fire = w_accept & bus_we_i & w_in_range;
    assign w_rd_data = w_in_range ? r_mem[w_word] : OOR_RDATA;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wcnt <= 4'd0;
        end else if (!bus_req_i || w_accept) begin
            r_wcnt <= 4'd0;
        end else if (r_wcnt != WAIT_MAX) begin
            r_wcnt <= r_wcnt + 4'd1;
        end
    end

    // Storage is deliberately not reset so contents survive a bus reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (bus_be_bi[i]) begin
                    r_mem[w_word][8*i +: 8] <= bus_wdata_bi[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_vld <= '0;
            for (int i = 0; i < RESP_DELAY; i++) begin
                r_dat[i] <= 32'h0;
            end
        end else begin
            r_vld[0] <= w_rd_fire;
            r_dat[0] <= w_rd_data;
            for (int i = 1; i < RESP_DELAY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign bus_resp_o   = r_vld[LAST];
    assign bus_rdata_bo = r_vld[LAST] ? r_dat[LAST] : 32'h0;

endmodule

// File: tb/tb_bus_resp_mem.sv
// Bench for bus_resp_mem: directed scenarios on two parameterisations plus randomized
// traffic against a queue-based memory/latency model.
module tb_bus_resp_mem;

    localparam int RD0 = 4;
    localparam int RD1 = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ack_a, resp_a, ack_b, resp_b;
    logic [31:0] rdata_a, rdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_resp_mem #(.mem_size(1024), .ACK_WAIT(0), .RESP_DELAY(RD0)) u_dut (
        .clk_i(clk), .arst_n_i(rst_n), .bus_req_i(req_a), .bus_we_i(we),
        .bus_addr_bi(addr), .bus_be_bi(be), .bus_wdata_bi(wdata),
        .bus_ack_o(ack_a), .bus_resp_o(resp_a), .bus_rdata_bo(rdata_a)
    );

    bus_resp_mem #(.mem_size(1024), .ACK_WAIT(3), .RESP_DELAY(RD1)) u_dut_ws (
        .clk_i(clk), .arst_n_i(rst_n), .bus_req_i(req_b), .bus_we_i(we),
        .bus_addr_bi(addr), .bus_be_bi(be), .bus_wdata_bi(wdata),
        .bus_ack_o(ack_b), .bus_resp_o(resp_b), .bus_rdata_bo(rdata_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; we = 1'b0;
        addr = 32'h0; be = 4'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL reset_ack_a: got %b want 0", ack_a); end
        n_checks++; if (resp_a !== 1'b0) begin n_fail++; $display("FAIL reset_resp_a: got %b want 0", resp_a); end
        n_checks++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_a: got %h want 0", rdata_a); end
        n_checks++; if (ack_b !== 1'b0) begin n_fail++; $display("FAIL reset_ack_b: got %b want 0", ack_b); end
        n_checks++; if (resp_b !== 1'b0) begin n_fail++; $display("FAIL reset_resp_b: got %b want 0", resp_b); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL release_ack_same_cycle: got %b want 1", ack_a); end
        n_checks++; if (ack_b !== 1'b0) begin n_fail++; $display("FAIL release_ack_b_waits: got %b want 0", ack_b); end
        req_a = 1'b0; req_b = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_byte_enable();
        logic [31:0] wd [2];
        logic [3:0]  bs [2];
        wd[0] = 32'h11223344; bs[0] = 4'hF;
        wd[1] = 32'hAABBCCDD; bs[1] = 4'h5;
        for (int i = 0; i < 2; i++) begin
            req_a = 1'b1; we = 1'b1; addr = 32'h10; be = bs[i]; wdata = wd[i];
            @(negedge clk);
            n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL be_write_ack%0d: got %b want 1", i, ack_a); end
            tick();
        end
        we = 1'b0;
        @(negedge clk);
        n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL be_read_ack: got %b want 1", ack_a); end
        tick();
        req_a = 1'b0;
        for (int k = 1; k <= RD0 + 1; k++) begin
            @(negedge clk);
            n_checks++; if (resp_a !== (k == RD0)) begin n_fail++; $display("FAIL be_resp_k%0d: got %b want %b", k, resp_a, (k == RD0)); end
            if (k == RD0) begin
                n_checks++; if (rdata_a !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_rdata: got %h want 11bb33dd", rdata_a); end
            end
            tick();
        end
    endtask

    task automatic test_wait_states();
        req_b = 1'b1; we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'hC0FFEE01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (ack_b !== (k == 3)) begin n_fail++; $display("FAIL ws_write_ack_k%0d: got %b want %b", k, ack_b, (k == 3)); end
            tick();
        end
        req_b = 1'b0;
        tick();
        // Abandoned write: req dropped at cycle 2
        req_b = 1'b1; wdata = 32'h0BADF00D;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) req_b = 1'b0;
            @(negedge clk);
            n_checks++; if (ack_b !== 1'b0) begin n_fail++; $display("FAIL ws_abandon_ack_k%0d: got %b want 0", k, ack_b); end
            tick();
        end
        req_b = 1'b1; we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (ack_b !== (k == 3)) begin n_fail++; $display("FAIL ws_read_ack_k%0d: got %b want %b", k, ack_b, (k == 3)); end
            tick();
        end
        req_b = 1'b0;
        for (int j = 1; j <= RD1 + 1; j++) begin
            @(negedge clk);
            n_checks++; if (resp_b !== (j == RD1)) begin n_fail++; $display("FAIL ws_resp_j%0d: got %b want %b", j, resp_b, (j == RD1)); end
            if (j == RD1) begin
                n_checks++; if (rdata_b !== 32'hC0FFEE01) begin n_fail++; $display("FAIL ws_no_abandon_write: got %h want c0ffee01", rdata_b); end
            end
            tick();
        end
    endtask

    task automatic test_rearm();
        req_b = 1'b1; we = 1'b0; addr = 32'h20;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_checks++; if (ack_b !== (k == 3 || k == 7)) begin n_fail++; $display("FAIL rearm_ack_k%0d: got %b want %b", k, ack_b, (k == 3 || k == 7)); end
            n_checks++; if (resp_b !== (k == 6 || k == 10)) begin n_fail++; $display("FAIL rearm_resp_k%0d: got %b want %b", k, resp_b, (k == 6 || k == 10)); end
            if (k == 6 || k == 10) begin
                n_checks++; if (rdata_b !== 32'hC0FFEE01) begin n_fail++; $display("FAIL rearm_rdata_k%0d: got %h want c0ffee01", k, rdata_b); end
            end
            tick();
            if (k == 7) req_b = 1'b0;
        end
    endtask

    task automatic test_pipelined_reads();
        for (int i = 0; i < 8; i++) begin
            req_a = 1'b1; we = (i < 4); be = 4'hF;
            addr = 32'((i % 4) * 4); wdata = 32'((i % 4) + 1);
            @(negedge clk);
            n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL pipe_ack_i%0d: got %b want 1", i, ack_a); end
            tick();
        end
        req_a = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++; if (resp_a !== (k < 4)) begin n_fail++; $display("FAIL pipe_resp_k%0d: got %b want %b", k, resp_a, (k < 4)); end
            if (k < 4) begin
                n_checks++; if (rdata_a !== 32'(k + 1)) begin n_fail++; $display("FAIL pipe_rdata_k%0d: got %h want %h", k, rdata_a, 32'(k + 1)); end
            end
            tick();
        end
    endtask

    task automatic test_out_of_range();
        logic        wes [3];
        logic [31:0] ads [3];
        wes[0] = 1'b1; ads[0] = 32'h1000;
        wes[1] = 1'b0; ads[1] = 32'h1000;
        wes[2] = 1'b0; ads[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            req_a = 1'b1; we = wes[i]; addr = ads[i]; be = 4'hF; wdata = 32'h12345678;
            @(negedge clk);
            n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL oor_ack_i%0d: got %b want 1", i, ack_a); end
            tick();
        end
        req_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (resp_a !== (k == 2 || k == 3)) begin n_fail++; $display("FAIL oor_resp_k%0d: got %b want %b", k, resp_a, (k == 2 || k == 3)); end
            if (k == 2) begin
                n_checks++; if (rdata_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL oor_rdata: got %h want deadbeef", rdata_a); end
            end
            if (k == 3) begin
                n_checks++; if (rdata_a !== 32'h1) begin n_fail++; $display("FAIL oor_no_alias: got %h want 1", rdata_a); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        req_b = 1'b1; we = 1'b0; addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (ack_b !== (k == 3)) begin n_fail++; $display("FAIL mid_ack_k%0d: got %b want %b", k, ack_b, (k == 3)); end
            tick();
        end
        req_b = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (resp_b !== 1'b0 || rdata_b !== 32'h0) begin n_fail++; $display("FAIL mid_in_reset: got %b/%h want 0/0", resp_b, rdata_b); end
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            n_checks++; if (resp_b !== 1'b0) begin n_fail++; $display("FAIL mid_discard_k%0d: got %b want 0", k, resp_b); end
        end
        tick();
        req_a = 1'b1; we = 1'b0; addr = 32'h10;
        @(negedge clk);
        tick();
        req_a = 1'b0;
        for (int k = 1; k <= RD0; k++) begin
            @(negedge clk);
            if (k == RD0) begin
                n_checks++; if (resp_a !== 1'b1 || rdata_a !== 32'h11BB33DD) begin n_fail++; $display("FAIL mid_retain_a: got %b/%h want 1/11bb33dd", resp_a, rdata_a); end
            end
            tick();
        end
        req_b = 1'b1; addr = 32'h20;
        repeat (4) tick();
        req_b = 1'b0;
        for (int j = 1; j <= RD1; j++) begin
            @(negedge clk);
            if (j == RD1) begin
                n_checks++; if (resp_b !== 1'b1 || rdata_b !== 32'hC0FFEE01) begin n_fail++; $display("FAIL mid_retain_b: got %b/%h want 1/c0ffee01", resp_b, rdata_b); end
            end
            tick();
        end
    endtask

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    task automatic test_random_traffic();
        rd_t         q[$];
        rd_t         e;
        logic [31:0] mdl [16];
        logic [29:0] idx;
        logic        do_req, do_we, exp_resp;
        logic [3:0]  b;
        logic [31:0] d, exp_data;
        for (int c = 0; c < 16 + 300 + RD0 + 2; c++) begin
            if (c < 16) begin
                do_req = 1'b1; do_we = 1'b1; idx = 30'(c); b = 4'hF; d = $urandom;
            end else if (c < 316) begin
                do_req = ($urandom_range(0, 3) != 0);
                do_we  = 1'($urandom_range(0, 1));
                b      = 4'($urandom);
                d      = $urandom;
                case ($urandom_range(0, 9))
                    0:       idx = 30'(1024 + $urandom_range(0, 4095));
                    1:       idx = 30'($urandom) | 30'h2000_0000;
                    default: idx = 30'($urandom_range(0, 15));
                endcase
            end else begin
                do_req = 1'b0; do_we = 1'b0; idx = 30'h0; b = 4'h0; d = 32'h0;
            end
            req_a = do_req; we = do_we; addr = {idx, 2'($urandom)}; be = b; wdata = d;
            @(negedge clk);
            exp_resp = (q.size() > 0) && (q[0].due == c);
            exp_data = exp_resp ? q[0].data : 32'h0;
            n_checks++; if (ack_a !== do_req) begin n_fail++; $display("FAIL rnd_ack_c%0d: got %b want %b", c, ack_a, do_req); end
            n_checks++; if (resp_a !== exp_resp) begin n_fail++; $display("FAIL rnd_resp_c%0d: got %b want %b", c, resp_a, exp_resp); end
            n_checks++; if (rdata_a !== exp_data) begin n_fail++; $display("FAIL rnd_rdata_c%0d: got %h want %h", c, rdata_a, exp_data); end
            if (exp_resp) void'(q.pop_front());
            if (do_req) begin
                if (do_we) begin
                    if (idx < 30'd16) begin
                        for (int i = 0; i < 4; i++) begin
                            if (b[i]) mdl[idx[3:0]][8*i +: 8] = d[8*i +: 8];
                        end
                    end
                end else begin
                    e.due  = c + RD0;
                    e.data = (idx < 30'd1024) ? mdl[idx[3:0]] : 32'hDEADBEEF;
                    q.push_back(e);
                end
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byte_enable();
        test_wait_states();
        test_rearm();
        test_pipelined_reads();
        test_out_of_range();
        test_reset_midflight();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
